// File: rtl/flow_pkg.sv
// Shared constants and helpers for the arbitrated mux blocks.
package flow_pkg;

  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Combinational rotating-priority encoder: first set request at or above ptr,
// wrapping to index 0; in fixed mode the search always starts at index 0.
module rr_prio_enc
  import flow_pkg::*;
#(
  parameter int unsigned N_CH  = 32,
  parameter int unsigned SEL_W = clog2_min1(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             mode,
  output logic [N_CH-1:0]  gnt_onehot,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);

  logic [SEL_W-1:0]  base;
  logic [2*N_CH-1:0] dbl;
  logic              found;

  always_comb begin
    base = mode ? '0 : ptr;
    // Lower copy keeps only requests at or above base; upper copy supplies the wrap.
    for (int unsigned i = 0; i < N_CH; i++) begin
      dbl[i]        = req[i] & (i >= 32'(base));
      dbl[i + N_CH] = req[i];
    end

    found   = 1'b0;
    gnt_idx = '0;
    for (int unsigned j = 0; j < 2 * N_CH; j++) begin
      if (!found && dbl[j]) begin
        found   = 1'b1;
        gnt_idx = (j >= N_CH) ? SEL_W'(j - N_CH) : SEL_W'(j);
      end
    end

    any = |req;
    for (int unsigned i = 0; i < N_CH; i++) begin
      gnt_onehot[i] = any && (gnt_idx == SEL_W'(i));
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel to 1 arbitrated mux with valid/ready on every channel and a
// registered output stage; channel chosen by round-robin or fixed priority.
module rr_arb_mux
  import flow_pkg::*;
#(
  parameter int unsigned N_CH     = 32,
  parameter int unsigned DATA_W   = 20,
  parameter int unsigned SEL_W    = clog2_min1(N_CH),
  parameter int unsigned ARB_MODE = ARB_RR
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_CH-1:0]               in_valid,
  input  logic [N_CH-1:0][DATA_W-1:0]   in_data,
  output logic [N_CH-1:0]               in_ready,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  output logic [SEL_W-1:0]              out_sel,
  input  logic                          out_ready
);

  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_sel_q, out_sel_d;

  logic [N_CH-1:0]   gnt_onehot;
  logic [SEL_W-1:0]  gnt_idx;
  logic              any;
  logic              load;
  logic              xfer;
  logic [DATA_W-1:0] mux_data;

  rr_prio_enc #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_enc (
    .req        (in_valid),
    .ptr        (ptr_q),
    .mode       (ARB_MODE == ARB_FIXED),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any)
  );

  always_comb begin
    load     = !out_valid_q || out_ready;
    xfer     = load && any && !rst;
    in_ready = xfer ? gnt_onehot : '0;

    // AND-OR select keeps the payload path free of index arithmetic.
    mux_data = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (gnt_onehot[i]) mux_data = mux_data | in_data[i];
    end

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = any;
      if (any) begin
        out_data_d = mux_data;
        out_sel_d  = gnt_idx;
      end
    end
    if (ARB_MODE == ARB_RR && xfer) begin
      ptr_d = (gnt_idx == SEL_W'(N_CH - 1)) ? '0 : gnt_idx + SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: 32-ch round-robin, 5-ch round-robin, 32-ch fixed priority.
module tb_rr_arb_mux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 32-channel round-robin
  logic [31:0]       v32, ir32;
  logic [31:0][19:0] d32;
  logic              r32, ov32;
  logic [19:0]       od32;
  logic [4:0]        os32;
  // 5-channel round-robin
  logic [4:0]        v5, ir5;
  logic [4:0][19:0]  d5;
  logic              r5, ov5;
  logic [19:0]       od5;
  logic [2:0]        os5;
  // 32-channel fixed priority
  logic [31:0]       vfp, irfp;
  logic [31:0][19:0] dfp;
  logic              rfp, ovfp;
  logic [19:0]       odfp;
  logic [4:0]        osfp;

  rr_arb_mux #(.N_CH(32), .DATA_W(20), .ARB_MODE(0)) u_rr32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_data(d32), .in_ready(ir32),
    .out_valid(ov32), .out_data(od32), .out_sel(os32), .out_ready(r32));

  rr_arb_mux #(.N_CH(5), .DATA_W(20), .ARB_MODE(0)) u_rr5 (
    .clk(clk), .rst(rst), .in_valid(v5), .in_data(d5), .in_ready(ir5),
    .out_valid(ov5), .out_data(od5), .out_sel(os5), .out_ready(r5));

  rr_arb_mux #(.N_CH(32), .DATA_W(20), .ARB_MODE(1)) u_fp32 (
    .clk(clk), .rst(rst), .in_valid(vfp), .in_data(dfp), .in_ready(irfp),
    .out_valid(ovfp), .out_data(odfp), .out_sel(osfp), .out_ready(rfp));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [4:0]  valid;
    logic        ready;
    logic [4:0]  exp_rdy;
    logic        exp_ov;
    logic [2:0]  exp_sel;
    logic [19:0] exp_data;
    logic [2:0]  exp_ptr;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      d32[i] = 20'(32'h100 + i);
      dfp[i] = 20'(32'h700 + i);
    end
    for (int i = 0; i < 5; i++) d5[i] = 20'(32'h500 + i);

    // sparse / wrap (5 channels), then backpressure
    tbl[0]  = '{5'b00010, 1'b1, 5'b00010, 1'b1, 3'd1, 20'h501, 3'd2};
    tbl[1]  = '{5'b10010, 1'b1, 5'b10000, 1'b1, 3'd4, 20'h504, 3'd0};
    tbl[2]  = '{5'b00010, 1'b1, 5'b00010, 1'b1, 3'd1, 20'h501, 3'd2};
    tbl[3]  = '{5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0, 20'h0,   3'd2};
    tbl[4]  = '{5'b11111, 1'b0, 5'b00100, 1'b1, 3'd2, 20'h502, 3'd3};
    tbl[5]  = '{5'b11111, 1'b0, 5'b00000, 1'b1, 3'd2, 20'h502, 3'd3};
    tbl[6]  = '{5'b11111, 1'b0, 5'b00000, 1'b1, 3'd2, 20'h502, 3'd3};
    tbl[7]  = '{5'b11111, 1'b0, 5'b00000, 1'b1, 3'd2, 20'h502, 3'd3};
    tbl[8]  = '{5'b11111, 1'b0, 5'b00000, 1'b1, 3'd2, 20'h502, 3'd3};
    tbl[9]  = '{5'b11111, 1'b1, 5'b01000, 1'b1, 3'd3, 20'h503, 3'd4};
    tbl[10] = '{5'b11111, 1'b1, 5'b10000, 1'b1, 3'd4, 20'h504, 3'd0};
    tbl[11] = '{5'b11111, 1'b1, 5'b00001, 1'b1, 3'd0, 20'h500, 3'd1};
    tbl[12] = '{5'b00001, 1'b0, 5'b00000, 1'b1, 3'd0, 20'h500, 3'd1};

    // Reset with all requests asserted
    v32 = '1; v5 = '1; vfp = '1;
    r32 = 1'b1; r5 = 1'b1; rfp = 1'b1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_in_ready32", 64'(ir32), 64'h0);
      chk("rst_in_ready5", 64'(ir5), 64'h0);
      chk("rst_out_valid32", 64'(ov32), 64'h0);
    end
    chk("rst_out_sel32", 64'(os32), 64'h0);
    chk("rst_out_data32", 64'(od32), 64'h0);
    chk("rst_ptr5", 64'(u_rr5.ptr_q), 64'h0);
    v5 = '0; vfp = '0;
    rst = 1'b0;
    #1;
    chk("first_grant32", 64'(ir32), 64'h1);

    // Round-robin fairness across all 32 channels, no bubbles
    for (int k = 0; k < 33; k++) begin
      tick();
      chk("rr_out_valid", 64'(ov32), 64'h1);
      chk("rr_out_sel", 64'(os32), 64'(k % 32));
      chk("rr_out_data", 64'(od32), 64'(32'h100 + (k % 32)));
    end
    v32 = '0;
    tick();
    chk("rr_drain", 64'(ov32), 64'h0);

    // Table-driven 5-channel sequences
    for (int n = 0; n < 13; n++) begin
      v5 = tbl[n].valid;
      r5 = tbl[n].ready;
      #1;
      chk($sformatf("tbl%0d_in_ready", n), 64'(ir5), 64'(tbl[n].exp_rdy));
      tick();
      chk($sformatf("tbl%0d_out_valid", n), 64'(ov5), 64'(tbl[n].exp_ov));
      if (tbl[n].exp_ov) begin
        chk($sformatf("tbl%0d_out_sel", n), 64'(os5), 64'(tbl[n].exp_sel));
        chk($sformatf("tbl%0d_out_data", n), 64'(od5), 64'(tbl[n].exp_data));
      end
      chk($sformatf("tbl%0d_ptr", n), 64'(u_rr5.ptr_q), 64'(tbl[n].exp_ptr));
    end

    // Reset while a beat is stalled: the beat must never appear
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(ir5), 64'h0);
    tick();
    rst = 1'b0;
    v5 = '0;
    r5 = 1'b1;
    chk("midrst_out_valid", 64'(ov5), 64'h0);
    chk("midrst_ptr", 64'(u_rr5.ptr_q), 64'h0);
    chk("midrst_out_sel", 64'(os5), 64'h0);
    tick();
    chk("midrst_no_beat", 64'(ov5), 64'h0);
    v5 = 5'b00100;
    tick();
    chk("midrst_next_sel", 64'(os5), 64'h2);
    chk("midrst_next_data", 64'(od5), 64'h502);
    v5 = '0;

    // Fixed priority: channel 1 wins while valid, starving 2 and 31
    vfp = 32'h8000_0006;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("fp_in_ready", 64'(irfp), 64'h2);
      tick();
      chk("fp_out_sel", 64'(osfp), 64'h1);
      chk("fp_out_data", 64'(odfp), 64'h701);
    end
    vfp = 32'h8000_0004;
    #1;
    chk("fp_in_ready_2", 64'(irfp), 64'h4);
    tick();
    chk("fp_out_sel_2", 64'(osfp), 64'h2);
    vfp = 32'h8000_0000;
    tick();
    chk("fp_out_sel_31", 64'(osfp), 64'd31);
    chk("fp_out_data_31", 64'(odfp), 64'h71f);
    vfp = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
